// File: rtl/if_id_queue.sv
// Fetch/decode decoupling FIFO of (pc, inst) pairs. An empty queue presents a
// zero bubble to decode; rst or flush_i drop every buffered entry in one cycle.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic [INST_W-1:0] if_inst_i,
  output logic              if_ready_o,
  input  logic              id_stall_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic [CNT_W-1:0]  count_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_reg   [DEPTH];
  logic [INST_W-1:0] inst_reg [DEPTH];
  logic [PTR_W-1:0]  wp_reg, wp_next;
  logic [PTR_W-1:0]  rp_reg, rp_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              push, pop, clear;

  // Ready looks only at the registered count, so a full queue refuses a push
  // even in a cycle that pops; this keeps id_stall_i off the fetch handshake.
  assign if_ready_o = (cnt_reg != CNT_W'(DEPTH));
  assign id_valid_o = (cnt_reg != '0);
  assign push       = if_valid_i & if_ready_o;
  assign pop        = id_valid_o & ~id_stall_i;
  assign clear      = rst | flush_i;

  assign id_pc_o    = id_valid_o ? pc_reg[rp_reg]   : '0;
  assign id_inst_o  = id_valid_o ? inst_reg[rp_reg] : '0;
  assign count_o    = cnt_reg;

  always_comb begin
    wp_next  = wp_reg;
    rp_next  = rp_reg;
    cnt_next = cnt_reg;
    if (clear) begin
      wp_next  = '0;
      rp_next  = '0;
      cnt_next = '0;
    end else begin
      if (push) wp_next = wp_reg + PTR_W'(1);
      if (pop)  rp_next = rp_reg + PTR_W'(1);
      cnt_next = cnt_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    wp_reg  <= wp_next;
    rp_reg  <= rp_next;
    cnt_reg <= cnt_next;
  end

  // Storage is never cleared; a push that coincides with a clear is wrong-path.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      pc_reg[wp_reg]   <= if_pc_i;
      inst_reg[wp_reg] <= if_inst_i;
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed and random stimulus for if_id_queue, checked every cycle against a
// queue-based model plus literal expectations for the directed scenarios.
module tb_if_id_queue;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush_i = 1'b0;
  logic              if_valid_i = 1'b0;
  logic [ADDR_W-1:0] if_pc_i = '0;
  logic [INST_W-1:0] if_inst_i = '0;
  logic              if_ready_o;
  logic              id_stall_i = 1'b0;
  logic              id_valid_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic [CNT_W-1:0]  count_o;

  int checks = 0;
  int errors = 0;
  bit live = 1'b0;
  bit verbose = 1'b1;
  logic [63:0] mq[$];

  if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .if_valid_i(if_valid_i),
    .if_pc_i(if_pc_i), .if_inst_i(if_inst_i), .if_ready_o(if_ready_o),
    .id_stall_i(id_stall_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain FIFO of {pc, inst}; the push decision uses pre-edge occupancy.
  always @(posedge clk) begin
    bit p, o;
    if (rst || flush_i) begin
      mq.delete();
    end else if (live) begin
      p = if_valid_i && (mq.size() < DEPTH);
      o = (mq.size() != 0) && !id_stall_i;
      if (o) void'(mq.pop_front());
      if (p) mq.push_back({if_pc_i, if_inst_i});
    end
    if (rst) live = 1'b1;
  end

  always @(negedge clk) begin
    logic [63:0] head;
    if (live) begin
      head = (mq.size() != 0) ? mq[0] : 64'd0;
      chk("count", 64'(count_o), 64'(mq.size()));
      chk("valid", 64'(id_valid_o), 64'(mq.size() != 0));
      chk("ready", 64'(if_ready_o), 64'(mq.size() < DEPTH));
      chk("head_pc", 64'(id_pc_o), {32'd0, head[63:32]});
      chk("head_inst", 64'(id_inst_o), {32'd0, head[31:0]});
    end
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Apply one cycle of inputs, let the edge consume them, return at edge+1.
  task automatic drive(input bit v, input logic [31:0] pc, input bit stall,
                       input bit fl, input bit r);
    if_valid_i = v;
    if_pc_i    = pc;
    if_inst_i  = inst_of(pc);
    id_stall_i = stall;
    flush_i    = fl;
    rst        = r;
    @(posedge clk);
    #1;
    if (verbose)
      $display("txn v=%0d pc=%h stall=%0d flush=%0d rst=%0d -> cnt=%0d valid=%0d head=%h",
               v, pc, stall, fl, r, count_o, id_valid_o, id_pc_o);
  endtask

  task automatic expect_state(input string tag, input int cnt, input logic [31:0] pc);
    chk({tag, "_cnt"}, 64'(count_o), 64'(cnt));
    chk({tag, "_pc"}, 64'(id_pc_o), 64'(pc));
    chk({tag, "_inst"}, 64'(id_inst_o), (cnt == 0) ? 64'd0 : 64'(inst_of(pc)));
  endtask

  initial begin
    // Reset state
    drive(0, 32'h0, 0, 0, 1);
    drive(0, 32'h0, 0, 0, 1);
    expect_state("reset", 0, 32'h0);
    chk("reset_ready", 64'(if_ready_o), 64'd1);
    chk("reset_valid", 64'(id_valid_o), 64'd0);

    // Single push with the literal instruction word
    if_valid_i = 1; if_pc_i = 32'h100; if_inst_i = 32'h3C01_0001;
    id_stall_i = 0; flush_i = 0; rst = 0;
    @(posedge clk); #1;
    chk("single_valid", 64'(id_valid_o), 64'd1);
    chk("single_pc", 64'(id_pc_o), 64'h100);
    chk("single_inst", 64'(id_inst_o), 64'h3C01_0001);
    chk("single_cnt", 64'(count_o), 64'd1);
    drive(0, 32'h0, 0, 0, 0);
    expect_state("single_drain", 0, 32'h0);

    // Fill while stalled, then a refused push
    for (int i = 0; i < 4; i++) drive(1, 32'h100 + 32'(4 * i), 1, 0, 0);
    expect_state("full", 4, 32'h100);
    chk("full_ready", 64'(if_ready_o), 64'd0);
    drive(1, 32'h110, 1, 0, 0);
    expect_state("full_hold", 4, 32'h100);
    drive(1, 32'h110, 0, 0, 0);
    expect_state("release0", 3, 32'h104);
    drive(1, 32'h110, 0, 0, 0);
    expect_state("release1", 3, 32'h108);
    drive(0, 32'h0, 0, 0, 0);
    expect_state("release2", 2, 32'h10C);
    drive(0, 32'h0, 0, 0, 0);
    expect_state("release3", 1, 32'h110);
    drive(0, 32'h0, 0, 0, 0);
    expect_state("release4", 0, 32'h0);

    // Steady state at two entries across pointer wraps
    drive(1, 32'h400, 1, 0, 0);
    drive(1, 32'h404, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h408 + 32'(4 * i), 0, 0, 0);
      expect_state("steady", 2, 32'h400 + 32'(4 * (i + 1)));
    end
    drive(0, 32'h0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
    expect_state("steady_drain", 0, 32'h0);

    // Flush with a same-cycle push
    for (int i = 0; i < 3; i++) drive(1, 32'h500 + 32'(4 * i), 1, 0, 0);
    expect_state("pre_flush", 3, 32'h500);
    drive(1, 32'h200, 1, 1, 0);
    expect_state("flush", 0, 32'h0);
    chk("flush_valid", 64'(id_valid_o), 64'd0);
    chk("flush_ready", 64'(if_ready_o), 64'd1);
    drive(1, 32'h300, 1, 0, 0);
    expect_state("post_flush", 1, 32'h300);
    drive(0, 32'h0, 0, 0, 0);
    expect_state("post_flush_drain", 0, 32'h0);

    // Reset while full and stalled
    for (int i = 0; i < 4; i++) drive(1, 32'h600 + 32'(4 * i), 1, 0, 0);
    expect_state("pre_rst", 4, 32'h600);
    drive(1, 32'h6F0, 1, 0, 1);
    expect_state("rst_full", 0, 32'h0);
    chk("rst_ready", 64'(if_ready_o), 64'd1);
    drive(1, 32'h700, 1, 0, 0);
    drive(1, 32'h704, 0, 0, 0);
    expect_state("post_rst", 1, 32'h704);
    drive(0, 32'h0, 0, 0, 0);
    expect_state("post_rst_drain", 0, 32'h0);

    // Random traffic; the per-cycle compare process carries the checking
    verbose = 1'b0;
    for (int i = 0; i < 10000; i++)
      drive(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)),
            ($urandom_range(99) < 5), 0);
    drive(0, 32'h0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
